// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// One access per three cycles: grant in IDLE, RAM strobe in ACCESS, done pulse in DONE.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,

  output logic              ram_cs,
  output logic              ram_rd,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;      // last granted port: 0 = A, 1 = B
  logic                owner_q;           // port being served: 0 = A, 1 = B
  logic                we_q;
  logic                ram_cs_q, ram_rd_q, ram_oe_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;

  logic                a_win, b_win;
  logic                a_gnt_c, b_gnt_c, grant;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Under contention the port that did not win last time takes the slot.
  always_comb begin
    a_win   = a_req & (~b_req | ptr_q);
    b_win   = b_req & (~a_req | ~ptr_q);
    a_gnt_c = rst_n & (state_q == IDLE) & a_win;
    b_gnt_c = rst_n & (state_q == IDLE) & b_win;
    grant   = a_gnt_c | b_gnt_c;
  end

  always_comb begin
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    if (b_gnt_c) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
          ptr_d   = b_gnt_c;
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (grant) begin
        owner_q <= b_gnt_c;
        we_q    <= sel_we;
      end
    end
  end

  // RAM strobes are registered so they are valid for the whole ACCESS cycle;
  // address and write data hold their last values between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs_q    <= 1'b0;
      ram_rd_q    <= 1'b1;
      ram_oe_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else if (grant) begin
      ram_cs_q    <= 1'b1;
      ram_rd_q    <= ~sel_we;
      ram_oe_q    <= ~sel_we;
      ram_addr_q  <= sel_addr;
      ram_wdata_q <= sel_wdata;
    end else begin
      ram_cs_q    <= 1'b0;
      ram_rd_q    <= 1'b1;
      ram_oe_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else if ((state_q == ACCESS) && !we_q) begin
      if (owner_q) begin
        b_rdata_q <= ram_rdata;
      end else begin
        a_rdata_q <= ram_rdata;
      end
    end
  end

  assign a_gnt     = a_gnt_c;
  assign b_gnt     = b_gnt_c;
  assign a_done    = (state_q == DONE) & ~owner_q;
  assign b_done    = (state_q == DONE) &  owner_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign ram_cs    = ram_cs_q;
  assign ram_rd    = ram_rd_q;
  assign ram_oe    = ram_oe_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x32 RAM and a
// per-cycle gnt->done / strobe-consistency monitor folded into the clock step.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, a_done, b_gnt, b_done;
  logic [31:0] a_rdata, b_rdata;
  logic        ram_cs, ram_rd, ram_oe;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [1:0]  a_hist = 2'b00;
  logic [1:0]  b_hist = 2'b00;

  logic [31:0] mem [256];
  logic        mem_ready = 1'b0;

  ram_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM: preload on first negedge, writes complete on the negedge of ACCESS.
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      mem[8'h05] <= 32'h1234_5678;
      mem[8'h20] <= 32'h1111_2222;
      mem_ready  <= 1'b1;
    end else if (ram_cs && !ram_rd) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  // Garbage when not enabled so a read sampled at the wrong time shows up.
  assign ram_rdata = (ram_cs && ram_oe) ? mem[ram_addr] : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check1(input string tag, input logic act, input logic exp);
    check(tag, 32'(act), 32'(exp));
  endtask

  // Advance one cycle; at the negedge run the invariant/latency monitor.
  task automatic tick();
    logic both, oe_bad;
    @(negedge clk);
    if (!rst_n) begin
      a_hist = 2'b00;
      b_hist = 2'b00;
    end else begin
      both   = a_gnt & b_gnt;
      oe_bad = ram_oe & ~(ram_cs & ram_rd);
      check1("mon_both_gnt", both, 1'b0);
      check1("mon_oe_needs_cs_rd", oe_bad, 1'b0);
      check1("mon_a_done_latency", a_done, a_hist[1]);
      check1("mon_b_done_latency", b_done, b_hist[1]);
      a_hist = {a_hist[0], a_gnt};
      b_hist = {b_hist[0], b_gnt};
    end
    @(posedge clk);
    #1;
  endtask

  // One complete access from an IDLE cycle; returns in the following IDLE cycle.
  task automatic access(input logic port, input logic we, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [31:0] ea, input logic [31:0] eb);
    logic exp_rd, g_sel, g_oth, d_sel, d_oth;
    exp_rd = ~we;
    if (port) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    #1;
    g_sel = port ? b_gnt : a_gnt;
    g_oth = port ? a_gnt : b_gnt;
    check1("gnt_winner", g_sel, 1'b1);
    check1("gnt_other", g_oth, 1'b0);
    tick();
    a_req = 1'b0; b_req = 1'b0;
    check1("acc_cs", ram_cs, 1'b1);
    check1("acc_rd", ram_rd, exp_rd);
    check1("acc_oe", ram_oe, exp_rd);
    check("acc_addr", 32'(ram_addr), 32'(addr));
    if (we) check("acc_wdata", ram_wdata, wd);
    check1("acc_no_a_done", a_done, 1'b0);
    check1("acc_no_b_done", b_done, 1'b0);
    tick();
    d_sel = port ? b_done : a_done;
    d_oth = port ? a_done : b_done;
    check1("done_winner", d_sel, 1'b1);
    check1("done_other", d_oth, 1'b0);
    check1("done_cs", ram_cs, 1'b0);
    check1("done_rd", ram_rd, 1'b1);
    check1("done_oe", ram_oe, 1'b0);
    check("done_addr_hold", 32'(ram_addr), 32'(addr));
    check("a_rdata", a_rdata, ea);
    check("b_rdata", b_rdata, eb);
    tick();
    check1("idle_a_done", a_done, 1'b0);
    check1("idle_b_done", b_done, 1'b0);
  endtask

  typedef struct packed {
    logic        port;   // 0 = A, 1 = B
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] ea;     // expected a_rdata after this access
    logic [31:0] eb;     // expected b_rdata after this access
  } vec_t;

  vec_t vecs [10] = '{
    '{1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000},
    '{1'b0, 1'b0, 8'h10, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000},
    '{1'b0, 1'b0, 8'h05, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000},
    '{1'b1, 1'b1, 8'h30, 32'h0BAD_F00D, 32'h1234_5678, 32'h0000_0000},
    '{1'b1, 1'b0, 8'h10, 32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF},
    '{1'b1, 1'b1, 8'h40, 32'h55AA_55AA, 32'h1234_5678, 32'hDEAD_BEEF},
    '{1'b0, 1'b0, 8'h40, 32'h0000_0000, 32'h55AA_55AA, 32'hDEAD_BEEF},
    '{1'b1, 1'b0, 8'h30, 32'h0000_0000, 32'h55AA_55AA, 32'h0BAD_F00D},
    '{1'b0, 1'b1, 8'h05, 32'hFFFF_FFFF, 32'h55AA_55AA, 32'h0BAD_F00D},
    '{1'b1, 1'b0, 8'h05, 32'h0000_0000, 32'h55AA_55AA, 32'hFFFF_FFFF}
  };

  initial begin
    logic ea_g, eb_g;
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h00; a_wdata = 32'h0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h00; b_wdata = 32'h0;

    // Reset state, with requests held high to show grants stay off.
    tick();
    tick();
    check1("rst_a_gnt", a_gnt, 1'b0);
    check1("rst_b_gnt", b_gnt, 1'b0);
    check1("rst_cs", ram_cs, 1'b0);
    check1("rst_rd", ram_rd, 1'b1);
    check1("rst_oe", ram_oe, 1'b0);
    check("rst_addr", 32'(ram_addr), 32'h0);
    check("rst_wdata", ram_wdata, 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    check1("rst_a_done", a_done, 1'b0);
    check1("rst_b_done", b_done, 1'b0);
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b1;
    tick();
    check1("post_rst_cs", ram_cs, 1'b0);

    // Single-requester traffic, back to back at 3-cycle spacing.
    for (int v = 0; v < 10; v++)
      access(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wd, vecs[v].ea, vecs[v].eb);

    // A request raised and withdrawn while busy must leave no trace.
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h60; b_wdata = 32'h600D_600D;
    #1;
    check1("drop_b_gnt", b_gnt, 1'b1);
    tick();
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 32'h0;
    #1;
    check1("drop_a_gnt_access", a_gnt, 1'b0);
    tick();
    check1("drop_a_gnt_done", a_gnt, 1'b0);
    a_req = 1'b0;
    tick();
    check1("drop_idle_cs", ram_cs, 1'b0);
    tick();
    check1("drop_idle_cs2", ram_cs, 1'b0);
    check("drop_mem10", mem[8'h10], 32'hDEAD_BEEF);
    check("drop_mem60", mem[8'h60], 32'h600D_600D);

    // Reset pulsed during the ACCESS cycle of a write, before the negedge.
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 32'hCAFE_F00D;
    #1;
    check1("abort_b_gnt", b_gnt, 1'b1);
    tick();
    b_req = 1'b0;
    check1("abort_cs_before", ram_cs, 1'b1);
    check("abort_wdata_before", ram_wdata, 32'hCAFE_F00D);
    #1 rst_n = 1'b0;
    #1;
    check1("abort_cs_async", ram_cs, 1'b0);
    check("abort_addr_async", 32'(ram_addr), 32'h0);
    check("abort_wdata_async", ram_wdata, 32'h0);
    tick();
    check1("abort_no_b_done", b_done, 1'b0);
    rst_n = 1'b1;
    tick();
    check1("abort_no_b_done2", b_done, 1'b0);
    check("abort_mem20", mem[8'h20], 32'h1111_2222);
    access(1'b0, 1'b0, 8'h20, 32'h0, 32'h1111_2222, 32'h0000_0000);

    // Continuous contention straight out of reset: A,B,A,B every 3 cycles.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h05;
    for (int c = 0; c < 12; c++) begin
      #1;
      ea_g = (c % 3 == 0) && ((c / 3) % 2 == 0);
      eb_g = (c % 3 == 0) && ((c / 3) % 2 == 1);
      check1("rr_a_gnt", a_gnt, ea_g);
      check1("rr_b_gnt", b_gnt, eb_g);
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;
    check("rr_a_rdata", a_rdata, 32'hDEAD_BEEF);
    check("rr_b_rdata", b_rdata, 32'hFFFF_FFFF);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
